// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - request/response and RAM port bundle for the load/store unit
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 20
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_str;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_str, ram_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_str, ram_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load/store front end onto a 32-bit word RAM
module mem_access_unit #(
    parameter int ADDR_WIDTH  = 20,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, LOAD, READ, WRITE, RESP, ERR} state_t;

    state_t                state, state_nxt;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic [31:0]           merge_q;
    logic [31:0]           out_q;

    logic                  accept;
    logic                  misaligned;
    logic [31:0]           addr_al;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [31:0]           load_val;
    logic [31:0]           merged;

    assign accept = bus.req_valid && (state == IDLE);

    always_comb begin
        misaligned = 1'b0;
        addr_al    = bus.req_addr;
        if (bus.req_size[1]) begin
            misaligned   = |bus.req_addr[1:0];
            addr_al[1:0] = 2'b00;
        end else if (bus.req_size[0]) begin
            misaligned = bus.req_addr[0];
            addr_al[0] = 1'b0;
        end
    end

    always_comb begin
        byte_v = bus.ram_rdata[7:0];
        case (addr_q[1:0])
            2'd1:    byte_v = bus.ram_rdata[15:8];
            2'd2:    byte_v = bus.ram_rdata[23:16];
            2'd3:    byte_v = bus.ram_rdata[31:24];
            default: byte_v = bus.ram_rdata[7:0];
        endcase
        half_v = addr_q[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & byte_v[7]}}, byte_v};
            2'b01:   load_val = {{16{~uns_q & half_v[15]}}, half_v};
            default: load_val = bus.ram_rdata;
        endcase
    end

    // Read-modify-write merge: only the addressed lane(s) take the new store data.
    always_comb begin
        merged = bus.ram_rdata;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                2'd3:    merged[31:24] = wdata_q[7:0];
                default: merged[7:0]   = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (misaligned && ALIGN_CHECK) state_nxt = ERR;
                    else if (!bus.req_we)          state_nxt = LOAD;
                    else if (bus.req_size[1])      state_nxt = WRITE;
                    else                           state_nxt = READ;
                end
            end
            LOAD:    state_nxt = RESP;
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP) || (state == ERR);
        bus.rsp_err   = (state == ERR);
        bus.rsp_rdata = out_q;
        if (state == ERR)       bus.rsp_rdata = 32'h0;
        else if (state == RESP) bus.rsp_rdata = we_q ? 32'h0 : rdata_q;
        bus.ram_addr  = addr_q[ADDR_WIDTH+1:2];
        bus.ram_str   = (state == WRITE) && rst;
        bus.ram_wdata = size_q[1] ? wdata_q : merge_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            merge_q <= 32'h0;
            out_q   <= 32'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= bus.req_we;
                size_q  <= bus.req_size;
                uns_q   <= bus.req_unsigned;
                addr_q  <= ALIGN_CHECK ? bus.req_addr[ADDR_WIDTH+1:0] : addr_al[ADDR_WIDTH+1:0];
                wdata_q <= bus.req_wdata;
            end
            if (state == LOAD) rdata_q <= load_val;
            if (state == READ) merge_q <= merged;
            if (bus.rsp_valid) out_q <= bus.rsp_rdata;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized and directed checks of mem_access_unit against a word-array model
module tb_mem_access_unit;
    localparam int AW = 8;
    localparam int NW = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_WIDTH(AW)) b0 ();
    mem_access_unit_if #(.ADDR_WIDTH(AW)) b1 ();

    mem_access_unit #(.ADDR_WIDTH(AW), .ALIGN_CHECK(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    mem_access_unit #(.ADDR_WIDTH(AW), .ALIGN_CHECK(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    logic [31:0] mem0 [NW];
    logic [31:0] mem1 [NW];
    logic [31:0] rmem [2][NW];

    assign b0.ram_rdata = mem0[b0.ram_addr];
    assign b1.ram_rdata = mem1[b1.ram_addr];
    always @(posedge clk) if (b0.ram_str) mem0[b0.ram_addr] <= b0.ram_wdata;
    always @(posedge clk) if (b1.ram_str) mem1[b1.ram_addr] <= b1.ram_wdata;

    int          n_vec = 0;
    int          n_err = 0;
    int          cur   = 0;
    logic [31:0] last_rd;

    logic        o_valid, o_err, o_ready, o_str;
    logic [31:0] o_rdata;
    always_comb begin
        if (cur == 1) begin
            o_valid = b1.rsp_valid; o_err = b1.rsp_err; o_ready = b1.req_ready;
            o_str   = b1.ram_str;   o_rdata = b1.rsp_rdata;
        end else begin
            o_valid = b0.rsp_valid; o_err = b0.rsp_err; o_ready = b0.req_ready;
            o_str   = b0.ram_str;   o_rdata = b0.rsp_rdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ram_word(input int sel, input int idx);
        return (sel == 1) ? mem1[idx] : mem0[idx];
    endfunction

    task automatic set_word(input int sel, input int idx, input logic [31:0] val);
        if (sel == 1) mem1[idx] = val; else mem0[idx] = val;
        rmem[sel][idx] = val;
    endtask

    task automatic drive(input int sel, input logic v, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        b0.req_valid = (sel == 0) && v; b1.req_valid = (sel == 1) && v;
        b0.req_we = we; b0.req_size = size; b0.req_unsigned = uns; b0.req_addr = addr; b0.req_wdata = wdata;
        b1.req_we = we; b1.req_size = size; b1.req_unsigned = uns; b1.req_addr = addr; b1.req_wdata = wdata;
    endtask

    // One request end to end; called #1 after a rising edge with the selected unit idle.
    task automatic do_op(input int sel, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] mask, ea, v, exp_rd;
        int nbytes, idx, sh, exp_lat, exp_wr, lat, wr, w;
        logic mis, exp_err;
        nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        mask   = (nbytes == 1) ? 32'hFF : (nbytes == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        mis    = (addr % nbytes) != 0;
        exp_err = 1'b0; exp_rd = 32'h0; exp_wr = 0;
        if (mis && sel == 0) begin
            exp_err = 1'b1; exp_lat = 1;
        end else begin
            ea  = addr - (addr % nbytes);
            idx = (ea / 4) % NW;
            sh  = 8 * (ea % 4);
            if (!we) begin
                v = (rmem[sel][idx] >> sh) & mask;
                if (!uns && nbytes < 4 && (v & ((mask + 1) >> 1)) != 0) v = v | ~mask;
                exp_rd = v; exp_lat = 2;
            end else begin
                rmem[sel][idx] = (rmem[sel][idx] & ~(mask << sh)) | ((wdata & mask) << sh);
                exp_lat = (nbytes == 4) ? 2 : 3; exp_wr = 1;
            end
        end
        cur = sel;
        w = 0;
        while (!o_ready && w < 10) begin @(posedge clk); #1; w++; end
        chk("ready_before_req", {31'b0, o_ready}, 32'h1);
        drive(sel, 1'b1, we, size, uns, addr, wdata);
        @(posedge clk); #1;
        drive(sel, 1'b0, we, size, uns, addr, wdata);
        lat = 1; wr = 0;
        while (lat <= 8) begin
            if (o_str) wr++;
            if (o_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        last_rd = o_rdata;
        chk("latency", lat, exp_lat);
        chk("rsp_err", {31'b0, o_err}, {31'b0, exp_err});
        chk("rsp_rdata", o_rdata, exp_rd);
        chk("ram_writes", wr, exp_wr);
        @(posedge clk); #1;
        chk("rdata_held", o_rdata, exp_rd);
        chk("valid_one_cycle", {31'b0, o_valid}, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < NW; i++) begin
            set_word(0, i, $urandom);
            set_word(1, i, $urandom);
        end
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        b0.req_valid = 1'b1; b1.req_valid = 1'b1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("rst_str0", {31'b0, b0.ram_str}, 32'h0);
            chk("rst_str1", {31'b0, b1.ram_str}, 32'h0);
        end
        b0.req_valid = 1'b0; b1.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_valid", {31'b0, b0.rsp_valid}, 32'h0);
        chk("rst_rdata", b0.rsp_rdata, 32'h0);
        chk("rst_ready", {31'b0, b0.req_ready}, 32'h1);
        chk("rst_ready1", {31'b0, b1.req_ready}, 32'h1);
        @(posedge clk); #1;

        do_op(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF);
        chk("sw_ram", ram_word(0, 'h40), 32'hDEAD_BEEF);
        do_op(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
        chk("lw_data", last_rd, 32'hDEAD_BEEF);

        set_word(0, 'h40, 32'h1122_3344);
        do_op(0, 1'b1, 2'b00, 1'b0, 32'h102, 32'hFFFF_FFAB);
        chk("sb_ram", ram_word(0, 'h40), 32'h11AB_3344);
        do_op(0, 1'b1, 2'b01, 1'b0, 32'h100, 32'h1234_CDEF);
        chk("sh_ram", ram_word(0, 'h40), 32'h11AB_CDEF);

        set_word(0, 'h40, 32'h80FF_7F01);
        do_op(0, 1'b0, 2'b00, 1'b0, 32'h102, 32'h0); chk("lb",  last_rd, 32'hFFFF_FFFF);
        do_op(0, 1'b0, 2'b00, 1'b1, 32'h102, 32'h0); chk("lbu", last_rd, 32'h0000_00FF);
        do_op(0, 1'b0, 2'b01, 1'b0, 32'h102, 32'h0); chk("lh",  last_rd, 32'hFFFF_80FF);
        do_op(0, 1'b0, 2'b01, 1'b1, 32'h100, 32'h0); chk("lhu", last_rd, 32'h0000_7F01);

        set_word(0, 'h40, 32'h1122_3344);
        do_op(0, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
        do_op(0, 1'b1, 2'b01, 1'b0, 32'h103, 32'h5566);
        chk("mis_ram_kept", ram_word(0, 'h40), 32'h1122_3344);
        set_word(1, 'h40, 32'h1122_3344);
        do_op(1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
        chk("noalign_lw", last_rd, 32'h1122_3344);
        do_op(1, 1'b1, 2'b01, 1'b0, 32'h103, 32'h5566);
        chk("noalign_sh", ram_word(1, 'h40), 32'h5566_3344);

        set_word(0, 'h40, 32'h1122_3344);
        cur = 0;
        drive(0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h101, 32'h77);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h77);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_str", {31'b0, b0.ram_str}, 32'h0);
        chk("midrst_valid", {31'b0, b0.rsp_valid}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_ready", {31'b0, b0.req_ready}, 32'h1);
        chk("midrst_valid2", {31'b0, b0.rsp_valid}, 32'h0);
        @(posedge clk); #1;
        chk("midrst_ram", ram_word(0, 'h40), 32'h1122_3344);

        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 150; k++) begin
                a = $urandom & 32'hFFFF_FC3F;
                do_op(s, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
            end
        end
        for (int i = 0; i < NW; i++) begin
            chk("final_ram0", mem0[i], rmem[0][i]);
            chk("final_ram1", mem1[i], rmem[1][i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
